// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending machine transaction controller.
package vend_pkg;

    localparam int CREDIT_W_DEF = 7;

    // Coin encoding used by both the acceptor and the change hopper.
    typedef enum logic [1:0] {
        COIN_1  = 2'd0,
        COIN_5  = 2'd1,
        COIN_10 = 2'd2,
        COIN_50 = 2'd3
    } coin_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    // Face value of a coin code.
    function automatic logic [7:0] coin_value(input logic [1:0] coin_type);
        logic [7:0] val;
        case (coin_type)
            COIN_1:  val = 8'd1;
            COIN_5:  val = 8'd5;
            COIN_10: val = 8'd10;
            COIN_50: val = 8'd50;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Signal bundle between the vending controller and its peripherals.
interface vend_if #(
    parameter int CREDIT_W = vend_pkg::CREDIT_W_DEF
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                sel_valid;
    logic [1:0]          sel_id;
    logic                cancel;
    logic                disp_ack;
    logic                chg_ready;
    logic [CREDIT_W-1:0] total_coin;
    logic [3:0]          avail;
    logic                disp_req;
    logic [1:0]          disp_id;
    logic                chg_valid;
    logic [1:0]          chg_coin;
    logic                coin_reject;
    logic                sel_deny;
    logic                busy;

    modport master (
        output coin_valid, coin_type, sel_valid, sel_id, cancel, disp_ack, chg_ready,
        input  total_coin, avail, disp_req, disp_id, chg_valid, chg_coin,
               coin_reject, sel_deny, busy
    );

    modport slave (
        input  coin_valid, coin_type, sel_valid, sel_id, cancel, disp_ack, chg_ready,
        output total_coin, avail, disp_req, disp_id, chg_valid, chg_coin,
               coin_reject, sel_deny, busy
    );
endinterface

// File: rtl/vend_change_gen.sv
// Greedy change picker: largest denomination not exceeding the credit.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = CREDIT_W_DEF
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          chg_coin,
    output logic [CREDIT_W-1:0] chg_value
);
    localparam logic [CREDIT_W-1:0] V50 = CREDIT_W'(coin_value(COIN_50));
    localparam logic [CREDIT_W-1:0] V10 = CREDIT_W'(coin_value(COIN_10));
    localparam logic [CREDIT_W-1:0] V5  = CREDIT_W'(coin_value(COIN_5));
    localparam logic [CREDIT_W-1:0] V1  = CREDIT_W'(coin_value(COIN_1));

    // Pick the denomination in 50/10/5/1 order; zero credit yields value 0.
    always_comb begin
        chg_coin  = COIN_1;
        chg_value = {CREDIT_W{1'b0}};
        if (credit >= V50) begin
            chg_coin  = COIN_50;
            chg_value = V50;
        end else if (credit >= V10) begin
            chg_coin  = COIN_10;
            chg_value = V10;
        end else if (credit >= V5) begin
            chg_coin  = COIN_5;
            chg_value = V5;
        end else if (credit >= V1) begin
            chg_coin  = COIN_1;
            chg_value = V1;
        end else begin
            chg_coin  = COIN_1;
            chg_value = {CREDIT_W{1'b0}};
        end
    end
endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit, selection, dispense and change FSM.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = CREDIT_W_DEF,
    parameter int MAX_CREDIT = 100,
    parameter int PRICE0     = 10,
    parameter int PRICE1     = 15,
    parameter int PRICE2     = 20,
    parameter int PRICE3     = 25
) (
    input  logic   clk,
    input  logic   reset,
    vend_if.slave  bus
);
    localparam logic [CREDIT_W:0]   MAX_EXT = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] P0 = CREDIT_W'(PRICE0);
    localparam logic [CREDIT_W-1:0] P1 = CREDIT_W'(PRICE1);
    localparam logic [CREDIT_W-1:0] P2 = CREDIT_W'(PRICE2);
    localparam logic [CREDIT_W-1:0] P3 = CREDIT_W'(PRICE3);

    state_t              state_r, state_n_s;
    logic [CREDIT_W-1:0] credit_r, credit_n_s;
    logic                disp_req_r, disp_req_n_s;
    logic [1:0]          disp_id_r, disp_id_n_s;
    logic                chg_valid_r, chg_valid_n_s;
    logic [1:0]          chg_coin_r, chg_coin_n_s;
    logic [CREDIT_W-1:0] chg_val_r, chg_val_n_s;
    logic                coin_reject_r, coin_reject_n_s;
    logic                sel_deny_r, sel_deny_n_s;
    logic                busy_r, busy_n_s;

    logic [CREDIT_W:0]   coin_val_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_fits_s;
    logic [CREDIT_W-1:0] price_s;
    logic [CREDIT_W-1:0] credit_after_chg_s;
    logic [CREDIT_W-1:0] pick_in_s;
    logic [1:0]          pick_coin_s;
    logic [CREDIT_W-1:0] pick_val_s;

    // The add is one bit wider so an over-limit coin cannot wrap below MAX_CREDIT.
    assign coin_val_s  = (CREDIT_W+1)'(coin_value(bus.coin_type));
    assign coin_sum_s  = {1'b0, credit_r} + coin_val_s;
    assign coin_fits_s = (coin_sum_s <= MAX_EXT);

    // While a coin is on offer, look ahead to the credit left after it transfers
    // so the next coin is ready on the following cycle.
    assign credit_after_chg_s = credit_r - chg_val_r;
    assign pick_in_s          = chg_valid_r ? credit_after_chg_s : credit_r;

    vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .credit    (pick_in_s),
        .chg_coin  (pick_coin_s),
        .chg_value (pick_val_s)
    );

    // Price lookup for the requested drink.
    always_comb begin
        case (bus.sel_id)
            2'd0:    price_s = P0;
            2'd1:    price_s = P1;
            2'd2:    price_s = P2;
            2'd3:    price_s = P3;
            default: price_s = P0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n_s       = state_r;
        credit_n_s      = credit_r;
        disp_req_n_s    = disp_req_r;
        disp_id_n_s     = disp_id_r;
        chg_valid_n_s   = chg_valid_r;
        chg_coin_n_s    = chg_coin_r;
        chg_val_n_s     = chg_val_r;
        coin_reject_n_s = 1'b0;
        sel_deny_n_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if ((state_r == ST_COLLECT) && bus.cancel) begin
                    state_n_s       = ST_CHANGE;
                    coin_reject_n_s = bus.coin_valid;
                    sel_deny_n_s    = bus.sel_valid;
                end else if (bus.coin_valid) begin
                    if (coin_fits_s) begin
                        credit_n_s = coin_sum_s[CREDIT_W-1:0];
                        state_n_s  = ST_COLLECT;
                    end else begin
                        coin_reject_n_s = 1'b1;
                    end
                    sel_deny_n_s = bus.sel_valid;
                end else if (bus.sel_valid) begin
                    if ((state_r == ST_COLLECT) && (credit_r >= price_s)) begin
                        credit_n_s   = credit_r - price_s;
                        disp_id_n_s  = bus.sel_id;
                        disp_req_n_s = 1'b1;
                        state_n_s    = ST_DISPENSE;
                    end else begin
                        sel_deny_n_s = 1'b1;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            ST_DISPENSE: begin
                coin_reject_n_s = bus.coin_valid;
                sel_deny_n_s    = bus.sel_valid;
                if (disp_req_r && bus.disp_ack) begin
                    disp_req_n_s = 1'b0;
                    if (credit_r != {CREDIT_W{1'b0}}) begin
                        state_n_s = ST_CHANGE;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    disp_req_n_s = disp_req_r;
                end
            end
            ST_CHANGE: begin
                coin_reject_n_s = bus.coin_valid;
                sel_deny_n_s    = bus.sel_valid;
                if (!chg_valid_r) begin
                    chg_valid_n_s = 1'b1;
                    chg_coin_n_s  = pick_coin_s;
                    chg_val_n_s   = pick_val_s;
                end else if (bus.chg_ready) begin
                    credit_n_s = credit_after_chg_s;
                    if (credit_after_chg_s == {CREDIT_W{1'b0}}) begin
                        state_n_s     = ST_IDLE;
                        chg_valid_n_s = 1'b0;
                        chg_coin_n_s  = 2'd0;
                        chg_val_n_s   = {CREDIT_W{1'b0}};
                    end else begin
                        chg_coin_n_s = pick_coin_s;
                        chg_val_n_s  = pick_val_s;
                    end
                end else begin
                    chg_valid_n_s = chg_valid_r;
                end
            end
            default: begin
                state_n_s     = ST_IDLE;
                credit_n_s    = {CREDIT_W{1'b0}};
                disp_req_n_s  = 1'b0;
                chg_valid_n_s = 1'b0;
            end
        endcase
        busy_n_s = (state_n_s == ST_DISPENSE) || (state_n_s == ST_CHANGE);
    end

    // State and output registers; reset discards any credit in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            credit_r      <= {CREDIT_W{1'b0}};
            disp_req_r    <= 1'b0;
            disp_id_r     <= 2'd0;
            chg_valid_r   <= 1'b0;
            chg_coin_r    <= 2'd0;
            chg_val_r     <= {CREDIT_W{1'b0}};
            coin_reject_r <= 1'b0;
            sel_deny_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_n_s;
            credit_r      <= credit_n_s;
            disp_req_r    <= disp_req_n_s;
            disp_id_r     <= disp_id_n_s;
            chg_valid_r   <= chg_valid_n_s;
            chg_coin_r    <= chg_coin_n_s;
            chg_val_r     <= chg_val_n_s;
            coin_reject_r <= coin_reject_n_s;
            sel_deny_r    <= sel_deny_n_s;
            busy_r        <= busy_n_s;
        end
    end

    assign bus.total_coin  = credit_r;
    assign bus.avail       = {credit_r >= P3, credit_r >= P2, credit_r >= P1, credit_r >= P0};
    assign bus.disp_req    = disp_req_r;
    assign bus.disp_id     = disp_id_r;
    assign bus.chg_valid   = chg_valid_r;
    assign bus.chg_coin    = chg_coin_r;
    assign bus.coin_reject = coin_reject_r;
    assign bus.sel_deny    = sel_deny_r;
    assign bus.busy        = busy_r;

endmodule
